inert_intf: RTL and testbench

INERT_INTF -- requirements
Module: inert_intf

---
 rtl/inert_intf.sv | 178 +++++++++++++++++
 tb/tb_inert_intf.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_intf.sv
// SPI front end for an inertial sensor: power-up delay, four config writes, then INT-driven read bursts.
// Define INERT_YAW_EN to add the yaw reads (6-read burst); otherwise yaw is constant zero.
module inert_intf #(
    parameter int INIT_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        clr_vld,
    output logic        vld,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw
);
`ifdef INERT_YAW_EN
    localparam int NREADS = 6;
`else
    localparam int NREADS = 4;
`endif
    localparam logic [2:0] LAST_INIT = 3'd3;
    localparam logic [2:0] LAST_READ = 3'(NREADS - 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, WAIT_INT, READ, UPDATE} state_t;

    state_t                state_q, state_d;
    logic [INIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic                  wrt_q, wrt_d;
    logic [15:0]           cmd_q, cmd_d;
    logic                  vld_q, vld_d;
    logic [15:0]           ptch_q, ptch_d;
    logic [15:0]           roll_q, roll_d;
    logic [8*NREADS-1:0]   hold_q, hold_d;
    logic                  int_meta_q, int_sync_q;
    logic                  unused_rd_hi;

    // Only the low byte of each read carries data.
    assign unused_rd_hi = ^rd_data[15:8];

    function automatic logic [15:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'h0D02;
            3'd1:    return 16'h1062;
            3'd2:    return 16'h1162;
            default: return 16'h1460;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
        end
    end

`ifdef INERT_YAW_EN
    logic [15:0] yaw_q, yaw_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) yaw_q <= '0;
        else        yaw_q <= yaw_d;
    end

    assign yaw = yaw_q;
`else
    assign yaw = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWR_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
            ptch_q  <= '0;
            roll_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        vld_d   = vld_q;
        ptch_d  = ptch_q;
        roll_d  = roll_q;
        hold_d  = hold_q;
`ifdef INERT_YAW_EN
        yaw_d   = yaw_q;
`endif
        if (clr_vld) vld_d = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                cnt_d = cnt_q + INIT_CNT_W'(1);
                if (&cnt_q) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            INIT: begin
                // pend_q marks a transaction in flight; a new wrt waits until its done.
                if (!pend_q) begin
                    wrt_d  = 1'b1;
                    cmd_d  = init_cmd(idx_q);
                    pend_d = 1'b1;
                end else if (done) begin
                    pend_d = 1'b0;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == LAST_INIT) state_d = WAIT_INT;
                end
            end
            WAIT_INT: begin
                if (int_sync_q) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                if (!pend_q) begin
                    wrt_d  = 1'b1;
                    cmd_d  = {8'hA2 + {5'd0, idx_q}, 8'h00};
                    pend_d = 1'b1;
                end else if (done) begin
                    pend_d = 1'b0;
                    idx_d  = idx_q + 3'd1;
                    for (int i = 0; i < NREADS; i++) begin
                        if (idx_q == 3'(i)) hold_d[8*i +: 8] = rd_data[7:0];
                    end
                    if (idx_q == LAST_READ) state_d = UPDATE;
                end
            end
            UPDATE: begin
                ptch_d  = hold_q[15:0];
                roll_d  = hold_q[31:16];
`ifdef INERT_YAW_EN
                yaw_d   = hold_q[47:32];
`endif
                vld_d   = 1'b1;
                state_d = WAIT_INT;
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    assign wrt  = wrt_q;
    assign cmd  = cmd_q;
    assign vld  = vld_q;
    assign ptch = ptch_q;
    assign roll = roll_q;

endmodule

// File: tb/tb_inert_intf.sv
// Scoreboard bench for inert_intf: SPI stub with 40-cycle done latency, random sensor bytes, consumer clears vld.
`timescale 1ns/1ps
module tb_inert_intf;
`ifdef INERT_YAW_EN
    localparam int NRD = 6;
`else
    localparam int NRD = 4;
`endif

    typedef struct packed { logic [15:0] p; logic [15:0] r; logic [15:0] y; } out_t;
    typedef struct packed { logic [7:0] b; logic last; logic collide; } rd_item_t;

    logic        clk = 1'b0;
    logic        rst_n, INT, done, clr_vld, wrt, vld;
    logic [15:0] rd_data, cmd, ptch, roll, yaw;

    logic [15:0] exp_cmd[$];
    rd_item_t    data_q[$];
    out_t        exp_out[$];
    int          tests = 0;
    int          fails = 0;
    bit          busy = 1'b0;

    inert_intf #(.INIT_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .clr_vld(clr_vld), .vld(vld),
        .ptch(ptch), .roll(roll), .yaw(yaw)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    // SPI slave stub and vld consumer
    initial begin : stub
        int       wait_cnt;
        bit       collide_next;
        bit       clr_chk;
        rd_item_t it;
        wait_cnt = 0; collide_next = 1'b0; clr_chk = 1'b0;
        forever begin
            @(negedge clk);
            done = 1'b0; clr_vld = 1'b0; rd_data = 16'($urandom);
            if (!rst_n) begin
                busy = 1'b0; collide_next = 1'b0; clr_chk = 1'b0;
                continue;
            end
            if (clr_chk) begin
                clr_chk = 1'b0;
                tests++;
                if (vld !== 1'b0) begin
                    fails++;
                    $display("FAIL clr_vld: vld=%0b after clear, required 0", vld);
                end
            end
            if (collide_next) begin
                clr_vld = 1'b1; collide_next = 1'b0;
            end else if (vld === 1'b1) begin
                clr_vld = 1'b1; clr_chk = 1'b1;
            end
            if (busy) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    busy = 1'b0; done = 1'b1;
                    if (cmd[15:8] >= 8'hA2 && cmd[15:8] <= 8'hA7) begin
                        if (data_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL stub_data: read 0x%04h with nothing planned, required a planned read", cmd);
                        end else begin
                            it = data_q.pop_front();
                            rd_data = {8'($urandom), it.b};
                            collide_next = it.last && it.collide;
                        end
                    end
                end
            end else if (wrt === 1'b1) begin
                busy = 1'b1; wait_cnt = 40;
            end
        end
    end

    // Monitor: command stream, transaction protocol, output samples
    initial begin : monitor
        bit          outst, first_wrt, prev_wrt, prev_vld;
        int          cyc;
        logic [15:0] held_cmd, ec;
        out_t        last, eo;
        outst = 1'b0; first_wrt = 1'b1; prev_wrt = 1'b0; prev_vld = 1'b0; cyc = 0;
        last = '0; held_cmd = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                outst = 1'b0; first_wrt = 1'b1; prev_wrt = 1'b0; prev_vld = 1'b0; cyc = 0; last = '0;
                continue;
            end
            cyc++;
            if (done === 1'b1) outst = 1'b0;
            if (wrt === 1'b1) begin
                tests++;
                if (outst) begin
                    fails++;
                    $display("FAIL wrt_outstanding: wrt=1 with transaction open, required 0");
                end
                tests++;
                if (prev_wrt) begin
                    fails++;
                    $display("FAIL wrt_width: wrt high 2 cycles, required 1");
                end
                tests++;
                if (exp_cmd.size() == 0) begin
                    fails++;
                    $display("FAIL cmd_extra: unexpected cmd 0x%04h, required none", cmd);
                end else begin
                    ec = exp_cmd.pop_front();
                    if (cmd !== ec) begin
                        fails++;
                        $display("FAIL cmd_seq: cmd 0x%04h, required 0x%04h", cmd, ec);
                    end
                end
                if (first_wrt) begin
                    tests++;
                    if (cyc < 16 || cyc > 19) begin
                        fails++;
                        $display("FAIL pwr_delay: first wrt at cycle %0d, required 16..19", cyc);
                    end
                    first_wrt = 1'b0;
                end
                outst = 1'b1; held_cmd = cmd;
            end else if (outst) begin
                tests++;
                if (cmd !== held_cmd) begin
                    fails++;
                    $display("FAIL cmd_hold: cmd 0x%04h, required 0x%04h", cmd, held_cmd);
                end
            end
            prev_wrt = (wrt === 1'b1);
            tests++;
            if (vld === 1'b1 && !prev_vld) begin
                if (exp_out.size() == 0) begin
                    fails++;
                    $display("FAIL sample_extra: vld set with p=%04h r=%04h y=%04h, required no sample", ptch, roll, yaw);
                end else begin
                    eo = exp_out.pop_front();
                    if (ptch !== eo.p || roll !== eo.r || yaw !== eo.y) begin
                        fails++;
                        $display("FAIL sample: p=%04h r=%04h y=%04h, required p=%04h r=%04h y=%04h",
                                 ptch, roll, yaw, eo.p, eo.r, eo.y);
                    end
                    last = eo;
                end
            end else if (ptch !== last.p || roll !== last.r || yaw !== last.y) begin
                fails++;
                $display("FAIL out_stable: p=%04h r=%04h y=%04h, required p=%04h r=%04h y=%04h",
                         ptch, roll, yaw, last.p, last.r, last.y);
                last = '{p: ptch, r: roll, y: yaw};
            end
            prev_vld = (vld === 1'b1);
        end
    end

    task automatic push_init();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1062);
        exp_cmd.push_back(16'h1162);
        exp_cmd.push_back(16'h1460);
    endtask

    task automatic plan_burst(input bit collide);
        logic [15:0] p, r, y;
        logic [7:0]  b [6];
        rd_item_t    it;
        p = 16'($urandom); r = 16'($urandom); y = 16'($urandom);
`ifndef INERT_YAW_EN
        y = 16'h0000;
`endif
        b[0] = p[7:0]; b[1] = p[15:8]; b[2] = r[7:0]; b[3] = r[15:8]; b[4] = y[7:0]; b[5] = y[15:8];
        for (int i = 0; i < NRD; i++) begin
            exp_cmd.push_back({8'(8'hA2 + i), 8'h00});
            it.b = b[i]; it.last = (i == NRD - 1); it.collide = collide;
            data_q.push_back(it);
        end
        exp_out.push_back('{p: p, r: r, y: y});
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_out.size() != 0 || busy) && n < budget) begin
            @(negedge clk); n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: timeout with %0d cmds, %0d samples pending, required 0", nm, exp_cmd.size(), exp_out.size());
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_started(input int left, input int budget, input string nm);
        int n = 0;
        while (exp_cmd.size() > left && n < budget) begin
            @(negedge clk); n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: %0d cmds pending, required <= %0d", nm, exp_cmd.size(), left);
        end
    endtask

    task automatic run_burst(input bit collide);
        plan_burst(collide);
        INT = 1'b1;
        wait_started(NRD - 1, 100, "burst_start");
        INT = 1'b0;
        wait_idle(1000, "burst");
    endtask

    task automatic check_zero(input string nm, input logic [15:0] act);
        tests++;
        if (act !== 16'h0000) begin
            fails++;
            $display("FAIL %s: got 0x%04h, required 0x0000", nm, act);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_zero({tag, "_wrt"}, {15'd0, wrt});
        check_zero({tag, "_cmd"}, cmd);
        check_zero({tag, "_vld"}, {15'd0, vld});
        check_zero({tag, "_ptch"}, ptch);
        check_zero({tag, "_roll"}, roll);
        check_zero({tag, "_yaw"}, yaw);
    endtask

    initial begin : main
        int n;
        rst_n = 1'b0; INT = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        push_init();
        rst_n = 1'b1;
        // INT pulse while init writes are in flight must not start a burst
        repeat (30) @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_idle(600, "init");

        run_burst(1'b0);
        run_burst(1'b1);
        run_burst(1'b0);

        for (int k = 0; k < 3; k++) plan_burst(1'b0);
        INT = 1'b1;
        wait_started(NRD - 1, 3000, "b2b_start");
        INT = 1'b0;
        wait_idle(3000, "b2b");

        plan_burst(1'b0);
        INT = 1'b1;
        n = 0;
        while (!(wrt === 1'b1 && cmd === 16'hA400) && n < 600) begin
            @(negedge clk); n++;
        end
        tests++;
        if (n >= 600) begin
            fails++;
            $display("FAIL third_read: no 0xA400 wrt, cmd 0x%04h, required 0xA400", cmd);
        end
        INT = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_cmd.delete(); data_q.delete(); exp_out.delete();
        push_init();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(600, "reinit");
        run_burst(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
